// File: rtl/ids_egress_pkt_buffer.sv
// ids_egress_pkt_buffer
// ---------------------------------------------------------------------------
// Store-and-forward packet buffer placed after the IDS master stage. Words are
// written as they arrive; a packet only becomes visible to the read side once
// its EOP word is stored ("committed"). A packet that overflows the buffer is
// dropped atomically by rolling the write pointer back to the last commit
// point, so a truncated packet can never reach the output. The input is never
// backpressured (in_rdy is 1 whenever out of reset).
//
// Framing: ctrl!=0 words before the first ctrl==0 word are module headers;
// the first ctrl!=0 word after a ctrl==0 word is EOP.
//
// Ports
//   clk           single clock
//   reset         asynchronous, active-low reset
//   in_data/in_ctrl/in_wr   word stream from the IDS master
//   in_rdy        input ready (1 whenever out of reset)
//   out_data/out_ctrl/out_wr  registered word stream to the next stage
//   out_rdy       downstream ready
//   pkt_fwd_cnt   packets forwarded  (IDS_EGRESS_STATS_EN, else tied 0)
//   pkt_drop_cnt  packets dropped    (IDS_EGRESS_STATS_EN, else tied 0)
//
// Build option: define IDS_EGRESS_STATS_EN to get saturating 32-bit
// forward/drop counters; otherwise both count ports are constant 0.
// ---------------------------------------------------------------------------
module ids_egress_pkt_buffer #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    output logic [31:0]           pkt_fwd_cnt,
    output logic [31:0]           pkt_drop_cnt
);

    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int WORD_W = DATA_WIDTH + CTRL_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {W_HDR, W_PAY, W_DROP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_HDR, R_PAY} rstate_t;

    logic [WORD_W-1:0]     mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, commit_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   pkt_cnt;

    wstate_t w_state, w_next;
    rstate_t r_state, r_next;

    logic wr_full, in_ctrl_nz;
    logic do_write, do_commit, do_drop;
    logic drop_pay, drop_pay_next;

    logic [WORD_W-1:0] rd_word;
    logic              rd_ctrl_nz, pop, pop_eop;

    // One slot stays empty so that full and empty are distinguishable.
    assign wr_full    = (wr_ptr + PTR_ONE) == rd_ptr;
    assign in_ctrl_nz = |in_ctrl;

    // ---- write side: framing, overflow detection, commit ----
    always_comb begin
        w_next        = w_state;
        do_write      = 1'b0;
        do_commit     = 1'b0;
        do_drop       = 1'b0;
        drop_pay_next = drop_pay;
        if (in_wr) begin
            case (w_state)
                W_HDR: begin
                    if (wr_full) begin
                        // A word seen in W_HDR can never be EOP.
                        do_drop       = 1'b1;
                        w_next        = W_DROP;
                        drop_pay_next = ~in_ctrl_nz;
                    end else begin
                        do_write = 1'b1;
                        if (!in_ctrl_nz) w_next = W_PAY;
                    end
                end
                W_PAY: begin
                    if (wr_full) begin
                        do_drop = 1'b1;
                        if (in_ctrl_nz) begin
                            w_next = W_HDR;
                        end else begin
                            w_next        = W_DROP;
                            drop_pay_next = 1'b1;
                        end
                    end else begin
                        do_write = 1'b1;
                        if (in_ctrl_nz) begin
                            do_commit = 1'b1;
                            w_next    = W_HDR;
                        end
                    end
                end
                W_DROP: begin
                    // drop_pay remembers whether a ctrl==0 word has gone by,
                    // which is what qualifies the next ctrl!=0 word as EOP.
                    if (in_ctrl_nz) begin
                        if (drop_pay) w_next = W_HDR;
                    end else begin
                        drop_pay_next = 1'b1;
                    end
                end
                default: w_next = W_HDR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_state    <= W_HDR;
            drop_pay   <= 1'b0;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            in_rdy     <= 1'b0;
        end else begin
            w_state  <= w_next;
            drop_pay <= drop_pay_next;
            in_rdy   <= 1'b1;
            if (do_drop)       wr_ptr <= commit_ptr;
            else if (do_write) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_commit)     commit_ptr <= wr_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr] <= {in_ctrl, in_data};
    end

    // ---- read side: pop committed words into the output registers ----
    assign rd_word    = mem[rd_ptr];
    assign rd_ctrl_nz = |rd_word[WORD_W-1:DATA_WIDTH];

    always_comb begin
        r_next  = r_state;
        pop     = 1'b0;
        pop_eop = 1'b0;
        case (r_state)
            R_IDLE: if (pkt_cnt != '0) r_next = R_HDR;
            R_HDR: begin
                pop = out_rdy && (rd_ptr != commit_ptr);
                if (pop && !rd_ctrl_nz) r_next = R_PAY;
            end
            R_PAY: begin
                pop = out_rdy && (rd_ptr != commit_ptr);
                if (pop && rd_ctrl_nz) begin
                    pop_eop = 1'b1;
                    r_next  = R_IDLE;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= R_IDLE;
            rd_ptr   <= '0;
            pkt_cnt  <= '0;
            out_wr   <= 1'b0;
            out_data <= '0;
            out_ctrl <= '0;
        end else begin
            r_state <= r_next;
            out_wr  <= pop;
            if (pop) begin
                out_data <= rd_word[DATA_WIDTH-1:0];
                out_ctrl <= rd_word[WORD_W-1:DATA_WIDTH];
                rd_ptr   <= rd_ptr + PTR_ONE;
            end
            // Commit and EOP pop in the same cycle cancel out.
            case ({do_commit, pop_eop})
                2'b10:   pkt_cnt <= pkt_cnt + CNT_ONE;
                2'b01:   pkt_cnt <= pkt_cnt - CNT_ONE;
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end

`ifdef IDS_EGRESS_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_fwd_cnt  <= '0;
            pkt_drop_cnt <= '0;
        end else begin
            if (pop_eop && (pkt_fwd_cnt != 32'hFFFF_FFFF))
                pkt_fwd_cnt <= pkt_fwd_cnt + 32'd1;
            if (do_drop && (pkt_drop_cnt != 32'hFFFF_FFFF))
                pkt_drop_cnt <= pkt_drop_cnt + 32'd1;
        end
    end
`else
    assign pkt_fwd_cnt  = '0;
    assign pkt_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_ids_egress_pkt_buffer.sv
`timescale 1ns/1ps
module tb_ids_egress_pkt_buffer;

    localparam int DW = 64;
    localparam int CW = 8;
    localparam int AW = 9;

`ifdef IDS_EGRESS_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          in_wr = 1'b0;
    logic          in_rdy;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic          out_wr;
    logic          out_rdy = 1'b1;
    logic [31:0]   pkt_fwd_cnt;
    logic [31:0]   pkt_drop_cnt;

    ids_egress_pkt_buffer #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
        .pkt_fwd_cnt(pkt_fwd_cnt), .pkt_drop_cnt(pkt_drop_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    logic [71:0] got_q[$];
    int          got_cyc[$];
    logic        rdy_prev = 1'b0;
    int          bp_viol = 0;
    always @(negedge clk) begin
        if (out_wr) begin
            got_q.push_back({out_ctrl, out_data});
            got_cyc.push_back(cyc);
            if (!rdy_prev) bp_viol++;
        end
        rdy_prev = out_rdy;
    end

    logic [71:0] exp_q[$];
    int  n_cmp = 0;
    int  n_fail = 0;
    bit  toggle = 1'b0;
    int  eop_cyc = 0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
        return STATS ? 32'(n) : 32'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle) out_rdy = ~out_rdy;
    endtask

    task automatic send_word(input logic [7:0] c, input logic [63:0] d, input bit keep);
        in_wr   = 1'b1;
        in_ctrl = c;
        in_data = d;
        if (keep) exp_q.push_back({c, d});
        tick();
    endtask

    // nhdr headers (ctrl FF), npay payload words (ctrl 00), one EOP (ctrl 80).
    task automatic send_pkt(input int nhdr, input int npay, input logic [63:0] base, input bit keep);
        int k;
        k = 0;
        for (int i = 0; i < nhdr; i++) begin send_word(8'hFF, base + 64'(k), keep); k++; end
        for (int i = 0; i < npay; i++) begin send_word(8'h00, base + 64'(k), keep); k++; end
        send_word(8'h80, base + 64'(k), keep);
        eop_cyc = cyc;
        in_wr = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (got_q.size() < exp_q.size() && n < budget) begin
            tick();
            n++;
        end
        repeat (6) tick();
        check({tag, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_w%0d", tag, i), 128'(got_q[i]), 128'(exp_q[i]));
    endtask

    task automatic clear_q();
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
    endtask

    initial begin
        int e_a;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_rdy", 128'(in_rdy), 128'(0));
        check("rst_out_wr", 128'(out_wr), 128'(0));
        check("rst_out_data", 128'(out_data), 128'(0));
        check("rst_out_ctrl", 128'(out_ctrl), 128'(0));
        check("rst_fwd", 128'(pkt_fwd_cnt), 128'(0));
        check("rst_drop", 128'(pkt_drop_cnt), 128'(0));
        reset = 1'b1;
        tick();
        tick();
        check("in_rdy_up", 128'(in_rdy), 128'(1));

        // 1: single 5-word packet, latency 2 after EOP write
        out_rdy = 1'b1;
        send_pkt(1, 3, 64'h1111_0000_0000_0000, 1'b1);
        e_a = eop_cyc;
        drain("t1", 50);
        if (got_cyc.size() > 0) check("t1_latency", 128'(got_cyc[0] - e_a), 128'(2));
        else check("t1_latency_seen", 128'(got_cyc.size()), 128'(1));
        check("t1_fwd", 128'(pkt_fwd_cnt), 128'(exp_cnt(1)));
        clear_q();

        // 2: 600-word packet dropped, following 5-word packet passes
        send_pkt(1, 598, 64'h2222_0000_0000_0000, 1'b0);
        send_pkt(1, 3, 64'h2222_1000_0000_0000, 1'b1);
        drain("t2", 50);
        check("t2_drop", 128'(pkt_drop_cnt), 128'(exp_cnt(1)));
        check("t2_fwd", 128'(pkt_fwd_cnt), 128'(exp_cnt(2)));
        clear_q();

        // 3: out_rdy toggling across three back-to-back 8-word packets
        bp_viol = 0;
        toggle = 1'b1;
        for (int p = 0; p < 3; p++)
            send_pkt(1, 6, 64'h3333_0000_0000_0000 + 64'(p * 256), 1'b1);
        drain("t3", 200);
        toggle = 1'b0;
        check("t3_bp_viol", 128'(bp_viol), 128'(0));
        check("t3_fwd", 128'(pkt_fwd_cnt), 128'(exp_cnt(5)));
        clear_q();

        // 4: fill exactly 511 words with out_rdy low, then one more packet drops
        out_rdy = 1'b0;
        tick();
        for (int p = 0; p < 7; p++)
            send_pkt(1, 71, 64'h4444_0000_0000_0000 + 64'(p * 1024), 1'b1);
        send_word(8'h00, 64'h4444_FFFF_0000_0000, 1'b0);
        send_word(8'h80, 64'h4444_FFFF_0000_0001, 1'b0);
        in_wr = 1'b0;
        repeat (4) tick();
        check("t4_none_out", 128'(got_q.size()), 128'(0));
        check("t4_drop", 128'(pkt_drop_cnt), 128'(exp_cnt(2)));
        check("t4_fwd_hold", 128'(pkt_fwd_cnt), 128'(exp_cnt(5)));
        out_rdy = 1'b1;
        drain("t4", 2000);
        check("t4_fwd", 128'(pkt_fwd_cnt), 128'(exp_cnt(12)));
        clear_q();

        // 5: commit of B coincides with EOP pop of A
        send_pkt(1, 3, 64'h5555_0000_0000_0000, 1'b1);
        e_a = eop_cyc;
        send_pkt(1, 4, 64'h5555_1000_0000_0000, 1'b1);
        drain("t5", 50);
        if (got_cyc.size() == 11) begin
            check("t5_a_first", 128'(got_cyc[0] - e_a), 128'(2));
            check("t5_a_eop", 128'(got_cyc[4] - e_a), 128'(6));
            check("t5_b_first", 128'(got_cyc[5] - got_cyc[4]), 128'(2));
        end else begin
            check("t5_words", 128'(got_cyc.size()), 128'(11));
        end
        check("t5_pkt_cnt", 128'(dut.pkt_cnt), 128'(0));
        check("t5_fwd", 128'(pkt_fwd_cnt), 128'(exp_cnt(14)));
        clear_q();

        // 6: reset mid-payload of packet 2 while packet 1 is stored
        out_rdy = 1'b0;
        send_pkt(1, 3, 64'h6666_0000_0000_0000, 1'b0);
        send_word(8'hFF, 64'h6666_1000_0000_0000, 1'b0);
        send_word(8'h00, 64'h6666_1000_0000_0001, 1'b0);
        send_word(8'h00, 64'h6666_1000_0000_0002, 1'b0);
        #2;
        in_wr = 1'b0;
        reset = 1'b0;
        #1;
        check("t6_in_rdy", 128'(in_rdy), 128'(0));
        check("t6_out_wr", 128'(out_wr), 128'(0));
        check("t6_out_data", 128'(out_data), 128'(0));
        check("t6_out_ctrl", 128'(out_ctrl), 128'(0));
        check("t6_fwd_rst", 128'(pkt_fwd_cnt), 128'(0));
        check("t6_drop_rst", 128'(pkt_drop_cnt), 128'(0));
        repeat (2) tick();
        reset = 1'b1;
        repeat (2) tick();
        check("t6_in_rdy_up", 128'(in_rdy), 128'(1));
        clear_q();
        out_rdy = 1'b1;
        send_pkt(1, 2, 64'h6666_2000_0000_0000, 1'b1);
        drain("t6", 50);
        check("t6_fwd", 128'(pkt_fwd_cnt), 128'(exp_cnt(1)));
        check("t6_drop", 128'(pkt_drop_cnt), 128'(exp_cnt(0)));
        check("bp_viol_total", 128'(bp_viol), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ids_egress_pkt_buffer.md
Name: ids_egress_pkt_buffer

Overview:
- Store-and-forward packet buffer directly downstream of the IDS master stage.
- Consumes the master's out_data/out_ctrl/out_wr stream and releases a packet to the next pipeline stage only once its last word is stored.
- Drops any packet that overflows the buffer; the drop is atomic via write-pointer rollback, so no truncated packet ever reaches the output.
- Lets the IDS stage run without seeing downstream stalls.

Parameters:
- DATA_WIDTH, 64, datapath width.
- CTRL_WIDTH, DATA_WIDTH/8, ctrl width.
- ADDR_WIDTH, 9, log2 buffer depth in words (512 words of DATA_WIDTH+CTRL_WIDTH bits).

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  DATA_WIDTH  word from IDS master out_data.
- in_ctrl  in  CTRL_WIDTH  ctrl from IDS master out_ctrl.
- in_wr  in  1  input word valid.
- in_rdy  out  1  input ready.
- out_data  out  DATA_WIDTH  word to next stage.
- out_ctrl  out  CTRL_WIDTH  ctrl to next stage.
- out_wr  out  1  output word valid.
- out_rdy  in  1  downstream ready.
- pkt_fwd_cnt  out  32  packets forwarded (optional feature).
- pkt_drop_cnt  out  32  packets dropped (optional feature).

Behaviour:
- Reset (reset=0, async): in_rdy=0, out_wr=0, out_data=0, out_ctrl=0, all pointers=0, stored-packet count=0, both FSMs idle, counters=0. Any in-flight packet is discarded.
- in_rdy=1 on every cycle out of reset. Overflow is handled by dropping, never by backpressure.
- Framing:
  - Words with ctrl!=0 before the first ctrl==0 word are module headers.
  - The first ctrl!=0 word after a ctrl==0 word is EOP.
- Write FSM states: W_HDR, W_PAY, W_DROP.
  - W_HDR: write word; ctrl==0 -> W_PAY.
  - W_PAY: write word; ctrl!=0 -> commit, then W_HDR.
  - Commit means commit_ptr <= wr_ptr+1 and stored-packet count +1.
  - Overflow in W_HDR or W_PAY: in_wr=1 while the buffer is full (wr_ptr+1==rd_ptr, one slot reserved).
    - Word is not written; wr_ptr <= commit_ptr; drop count +1.
    - If the word is EOP -> W_HDR, else -> W_DROP.
  - W_DROP: discard words until the EOP-qualified ctrl!=0 word, then -> W_HDR.
- Pointers are ADDR_WIDTH bits and wrap modulo 2^ADDR_WIDTH.
- Read side sees only committed data: occupancy is computed against commit_ptr, not wr_ptr.
- Read FSM states: R_IDLE, R_HDR, R_PAY.
  - R_IDLE -> R_HDR when stored-packet count>0.
  - Each cycle with out_rdy=1 in R_HDR/R_PAY: pop one word into registered outputs and assert out_wr for exactly that cycle.
  - Header/payload/EOP tracking mirrors the write FSM.
  - On popping EOP: stored-packet count -1, -> R_IDLE.
- out_rdy=0: out_wr=0 next cycle, no pop, outputs hold their last value.
- Latency: EOP written at cycle N; first out_wr of that packet at N+2 at the earliest, given out_rdy=1.
- Throughput: one word per cycle on both sides. Back-to-back packets need no idle cycle on the input. On the output, one R_IDLE cycle is allowed between packets.
- Simultaneous commit (+1) and read-EOP (-1) in the same cycle: stored-packet count unchanged.
- Packets longer than 2^ADDR_WIDTH-1 words are always dropped.
- Mid-packet reset: the partial packet is lost; the first word after reset release is treated as W_HDR.

Optional Feature:
- Macro: IDS_EGRESS_STATS_EN.
- Defined:
  - pkt_fwd_cnt increments on each popped EOP.
  - pkt_drop_cnt increments on each overflow event.
  - Both counters are 32-bit, saturate at 0xFFFFFFFF, and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- Packet: 1 header (ctrl=0xFF), 3 payload (ctrl=0), EOP (ctrl=0x80), out_rdy=1 -> identical 5 words out, first out_wr 2 cycles after EOP write, pkt_fwd_cnt=1.
- Packet longer than buffer: 600 words with ADDR_WIDTH=9, then a 5-word packet -> only the 5-word packet emerges; pkt_drop_cnt=1; no partial words out.
- Backpressure: out_rdy toggles 1/0 every cycle across three back-to-back 8-word packets -> all 24 words emerge in order, out_wr never high while out_rdy was low the prior cycle, no loss.
- Fill exactly: 511 words stored as whole packets with out_rdy=0 -> no drop. One more 2-word packet -> dropped, pkt_drop_cnt=1. Release out_rdy -> the earlier packets drain intact.
- Commit and read-EOP in the same cycle -> stored-packet count unchanged, next packet starts after one R_IDLE cycle.
- Assert reset mid-payload of packet 2 with packet 1 stored -> all outputs 0 immediately. After release, a new 4-word packet passes intact and the old data never appears.
